// File: rtl/sum_pkg.sv
// ----------------------------------------------------------------------------
// sum_pkg
// Shared definitions for the nibble collector and the eight-operand adder.
//   NIB_W / NUM_NIB : operand width and operands per frame
//   SUM_W           : width of the frame sum (8 x 15 = 120 fits in 7 bits)
//   coll_state_t    : collector state {FILL, HOLD}
//   slot_base()     : bit offset of slot i in a packed frame (slot 0 = a)
// ----------------------------------------------------------------------------
package sum_pkg;

    localparam int NIB_W   = 4;
    localparam int NUM_NIB = 8;
    localparam int SUM_W   = 7;
    localparam int CNT_W   = $clog2(NUM_NIB);
    localparam int FRAME_W = NIB_W * NUM_NIB;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } coll_state_t;

    // The adder unpacks a..h with the same function, so both sides agree on order.
    function automatic int slot_base(input int i);
        return NIB_W * i;
    endfunction

endpackage

// File: rtl/nibble_collector.sv
// ----------------------------------------------------------------------------
// nibble_collector
// Collects a serial stream of 4-bit operands into an eight-slot frame and
// presents the frame in parallel to the adder stage.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clr        synchronous frame abort (wins over same-cycle accept/consume)
//   in_valid   upstream operand valid
//   in_ready   collector can accept (state decode only)
//   in_data    operand
//   out_valid  full frame held (state decode only)
//   out_ready  adder consumes the frame
//   out_frame  slot i at bits [NIB_W*i +: NIB_W]
//   out_sum    running frame sum, present only with NIBBLE_COLLECTOR_SUM_EN
//
// Build option: define NIBBLE_COLLECTOR_SUM_EN to add the 7-bit accumulator
// and the out_sum port.
// ----------------------------------------------------------------------------
module nibble_collector
    import sum_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NIB_W-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FRAME_W-1:0] out_frame
`ifdef NIBBLE_COLLECTOR_SUM_EN
    ,
    output logic [SUM_W-1:0]   out_sum
`endif
);

    coll_state_t          r_state;
    coll_state_t          w_next_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [FRAME_W-1:0]   r_frame;
    logic                 w_accept;
    logic                 w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= FILL;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = (r_state == FILL);
        out_valid    = (r_state == HOLD);
        w_accept     = in_valid & in_ready;
        w_last       = (r_cnt == CNT_W'(NUM_NIB - 1));
        case (r_state)
            FILL:    if (w_accept && w_last) w_next_state = HOLD;
            HOLD:    if (out_ready)          w_next_state = FILL;
            default: w_next_state = FILL;
        endcase
        if (clr) w_next_state = FILL;
    end

    // Slots are only written on accept, so a consumed frame stays visible
    // until the next frame overwrites it slot by slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_frame <= '0;
        end else if (clr) begin
            r_cnt   <= '0;
            r_frame <= '0;
        end else if (w_accept) begin
            r_frame[slot_base(int'(r_cnt)) +: NIB_W] <= in_data;
            r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

    assign out_frame = r_frame;

`ifdef NIBBLE_COLLECTOR_SUM_EN
    logic [SUM_W-1:0] r_sum;

    // cnt == 0 on accept marks the first operand of a new frame: restart the sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else if (clr) begin
            r_sum <= '0;
        end else if (w_accept) begin
            if (r_cnt == '0) r_sum <= SUM_W'(in_data);
            else             r_sum <= r_sum + SUM_W'(in_data);
        end
    end

    assign out_sum = r_sum;
`endif

endmodule

// File: tb/tb_nibble_collector.sv
module tb_nibble_collector;
    import sum_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               clr;
    logic               in_valid;
    logic               in_ready;
    logic [NIB_W-1:0]   in_data;
    logic               out_valid;
    logic               out_ready;
    logic [FRAME_W-1:0] out_frame;
`ifdef NIBBLE_COLLECTOR_SUM_EN
    logic [SUM_W-1:0]   out_sum;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nibble_collector dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_frame (out_frame)
`ifdef NIBBLE_COLLECTOR_SUM_EN
        ,
        .out_sum   (out_sum)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: frame is the operands placed in arrival order, a in the low nibble.
    function automatic logic [31:0] pack(input logic [3:0] q[$]);
        logic [31:0] f = '0;
        for (int i = 0; i < q.size(); i++) f = f | (32'(q[i]) << (4 * i));
        return f;
    endfunction

    function automatic int qsum(input logic [3:0] q[$]);
        int s = 0;
        foreach (q[i]) s += int'(q[i]);
        return s;
    endfunction

    task automatic chk_sum(input string tag, input int exp);
`ifdef NIBBLE_COLLECTOR_SUM_EN
        chk(tag, 32'(out_sum), 32'(exp));
`endif
    endtask

    // Presents the operands in d, one accept per (gap+1) cycles.
    task automatic feed(input string tag, input logic [3:0] d[$], input int gap);
        foreach (d[i]) begin
            in_valid = 1'b1;
            in_data  = d[i];
            chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
            tick();
            in_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin
                if (i != d.size() - 1) chk({tag, "_gap_no_valid"}, 32'(out_valid), 32'd0);
                tick();
            end
        end
    endtask

    initial begin
        logic [3:0] d[$];
        logic [3:0] q[$];
        logic [3:0] nib;
        int frames;

        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #3;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_frame",     out_frame,      32'd0);
        chk_sum("rst_sum", 0);
        @(negedge clk); rst_n = 1'b1;
        tick();

        // Back-to-back 1..8, adder always ready.
        out_ready = 1'b1;
        d = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
        foreach (d[i]) begin
            in_valid = 1'b1; in_data = d[i];
            chk("b2b_in_ready", 32'(in_ready), 32'd1);
            chk("b2b_no_valid", 32'(out_valid), 32'd0);
            tick();
        end
        in_valid = 1'b0;
        chk("b2b_out_valid", 32'(out_valid), 32'd1);
        chk("b2b_in_ready_hold", 32'(in_ready), 32'd0);
        chk("b2b_frame", out_frame, 32'h8765_4321);
        chk("b2b_frame_model", out_frame, pack(d));
        chk_sum("b2b_sum", 36);
        tick();
        chk("b2b_in_ready_back", 32'(in_ready), 32'd1);
        chk("b2b_valid_drop", 32'(out_valid), 32'd0);
        chk("b2b_frame_kept", out_frame, 32'h8765_4321);

        // Eight 0xF with the adder stalled for 5 cycles; upstream keeps pushing.
        out_ready = 1'b0;
        d = {4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
        feed("stall", d, 0);
        in_valid = 1'b1; in_data = 4'h3;
        for (int c = 0; c < 5; c++) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_frame", out_frame, 32'hFFFF_FFFF);
            chk_sum("stall_sum", 120);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stall_frame_6th", out_frame, 32'hFFFF_FFFF);
        tick();
        chk("stall_consumed", 32'(out_valid), 32'd0);
        chk("stall_in_ready_back", 32'(in_ready), 32'd1);

        // Gapped: one accept every third cycle.
        d = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
        out_ready = 1'b0;
        feed("gap", d, 2);
        chk("gap_valid", 32'(out_valid), 32'd1);
        chk("gap_frame", out_frame, 32'h8765_4321);
        chk_sum("gap_sum", 36);
        out_ready = 1'b1;
        tick();
        chk("gap_consumed", 32'(out_valid), 32'd0);

        // clr after 5 accepts, with a same-cycle offered operand that must be dropped.
        d = {};
        for (int i = 0; i < 5; i++) d.push_back(4'($urandom_range(1, 15)));
        feed("clr_pre", d, 0);
        clr = 1'b1; in_valid = 1'b1; in_data = 4'h5;
        tick();
        clr = 1'b0; in_valid = 1'b0;
        chk("clr_frame", out_frame, 32'd0);
        chk("clr_valid", 32'(out_valid), 32'd0);
        chk("clr_in_ready", 32'(in_ready), 32'd1);
        chk_sum("clr_sum", 0);
        d = {4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9};
        out_ready = 1'b0;
        feed("clr_post", d, 0);
        chk("clr_no_early_valid", 32'(out_valid), 32'd0);
        d = {4'd9};
        feed("clr_last", d, 0);
        chk("clr_post_valid", 32'(out_valid), 32'd1);
        chk("clr_post_frame", out_frame, 32'h9999_9999);
        chk_sum("clr_post_sum", 72);
        // clr in HOLD with a same-cycle consume: clr wins and zeroes the slots.
        clr = 1'b1; out_ready = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_hold_valid", 32'(out_valid), 32'd0);
        chk("clr_hold_frame", out_frame, 32'd0);
        chk_sum("clr_hold_sum", 0);

        // Reset while holding a frame.
        out_ready = 1'b0;
        d = {};
        for (int i = 0; i < 8; i++) d.push_back(4'($urandom));
        feed("rsth", d, 0);
        chk("rsth_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rsth_async_valid", 32'(out_valid), 32'd0);
        chk("rsth_async_frame", out_frame, 32'd0);
        chk("rsth_async_in_ready", 32'(in_ready), 32'd1);
        chk_sum("rsth_async_sum", 0);
        @(negedge clk); rst_n = 1'b1;
        tick();
        d = {};
        for (int i = 0; i < 8; i++) d.push_back(4'($urandom));
        feed("rsth_new", d, 0);
        chk("rsth_new_valid", 32'(out_valid), 32'd1);
        chk("rsth_new_frame", out_frame, pack(d));
        chk_sum("rsth_new_sum", qsum(d));
        out_ready = 1'b1;
        tick();
        chk("rsth_new_consumed", 32'(out_valid), 32'd0);

        // Random traffic against a queue model: the frame is full exactly when
        // eight operands are queued; upstream obeys hold-while-stalled.
        q = {};
        frames = 0;
        in_valid = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!(in_valid && q.size() == NUM_NIB)) begin
                in_valid = 1'($urandom_range(0, 1));
                nib = 4'($urandom);
                in_data = nib;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            chk("rnd_in_ready", 32'(in_ready), 32'(q.size() != NUM_NIB));
            chk("rnd_out_valid", 32'(out_valid), 32'(q.size() == NUM_NIB));
            if (q.size() == NUM_NIB) begin
                chk("rnd_frame", out_frame, pack(q));
                chk_sum("rnd_sum", qsum(q));
                if (out_ready) begin
                    q = {};
                    frames++;
                end
            end else if (in_valid) begin
                q.push_back(in_data);
            end
            tick();
        end
        in_valid = 1'b0;
        chk("rnd_frames_seen", 32'(frames > 5), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nibble_collector.md
# nibble_collector

Upstream feeder for the eight-operand 4-bit adder. Accepts a serial stream of 4-bit operands over a valid/ready handshake, buffers eight of them into a frame (operands a..h), then presents the frame in parallel with a valid/ready handshake to the adder stage. Optionally computes the frame's 7-bit running sum, used to cross-check the adder.

## Interface
- NIB_W, 4, operand width in bits
- NUM_NIB, 8, operands per frame; counter width is clog2(NUM_NIB)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active-low
- clr  in  1  synchronous frame abort
- in_valid  in  1  upstream operand valid
- in_ready  out  1  collector can accept an operand
- in_data  in  NIB_W  operand
- out_valid  out  1  full frame held
- out_ready  in  1  adder consumes the frame
- out_frame  out  NIB_W*NUM_NIB  slot i at bits [NIB_W*i+NIB_W-1 : NIB_W*i]; slot 0 = a … slot 7 = h
- out_sum  out  7  sum of the frame (only with the macro)

One clock; reset is asynchronous and active-low (clk, rst_n).

## Operation
- Reset values: state FILL, cnt 0, in_ready 1, out_valid 0, out_frame 0, out_sum 0.
- States: FILL, HOLD.
- FILL:
  - in_ready = 1.
  - On accept (in_valid & in_ready), write in_data to slot cnt and increment cnt.
  - Accept at cnt == NUM_NIB-1: go to HOLD, cnt wraps to 0.
- HOLD:
  - in_ready = 0 and out_valid = 1.
  - out_frame and out_sum stay stable until consumed.
  - On out_ready, go to FILL.
  - Slots keep their old values until overwritten.
- Handshakes:
  - Upstream must hold in_data while in_valid is high and in_ready is low.
  - out_valid never drops without out_ready.
- clr (synchronous):
  - Goes to FILL, cnt 0, out_valid 0, all slots and sum 0.
  - Any same-cycle accept or consume is discarded; clr wins.
- Reset mid-frame: partial frame is lost and outputs return to reset values immediately.
- Arithmetic: operands are unsigned and zero-extended. Maximum sum is 8×15 = 120, which fits in 7 bits with no overflow.

## Timing
- in_ready and out_valid are registered-state decodes, with no combinational path from in_valid or out_ready.
- out_valid rises the cycle after the 8th accept.
- After a consume, in_ready is high the next cycle. One bubble: peak throughput is 8 operands per 9 cycles.
- out_frame and out_sum are registers; the adder may sample them on any cycle out_valid is high.

## Configuration
- NIBBLE_COLLECTOR_SUM_EN defined:
  - A 7-bit accumulator adds each accepted operand.
  - It clears on clr, reset, or on the first accept of a new frame.
  - out_sum equals the sum of slots 0..7 whenever out_valid is high.
- Undefined: accumulator and out_sum port are absent, with no other behavioural change.

## Structure
- Shared package sum_pkg holds:
  - NIB_W, NUM_NIB and SUM_W = 7.
  - Collector state enum {FILL, HOLD}.
  - The slot-index function (slot base = NIB_W*i). The adder stage uses the same function to unpack a..h.
- Single flat module; no sub-module is warranted.

## Test plan
- Reset, then 8 back-to-back accepts of 1,2,3,4,5,6,7,8 with out_ready held 1:
  - out_valid rises the cycle after the 8th accept.
  - out_frame = 0x87654321, out_sum = 36.
  - in_ready returns 1 two cycles after the 8th accept.
- Eight accepts of 0xF with out_ready held 0 for 5 cycles:
  - out_frame = 0xFFFFFFFF and out_sum = 120, held stable.
  - in_ready stays 0 for all 5 cycles.
  - Consume on the 6th cycle.
- Gapped in_valid (accept every 3rd cycle): frame contents and order identical to the back-to-back case.
- clr asserted after 5 accepts:
  - cnt returns to 0.
  - The next 8 accepts of 9 form frame 0x99999999 with out_sum = 72; no stale slots.
- rst_n pulled low while in HOLD:
  - out_valid goes 0 asynchronously and out_frame is 0.
  - After release, in_ready = 1 and a new frame collects normally.
- Build without NIBBLE_COLLECTOR_SUM_EN: out_sum is absent and the first scenario gives an identical out_frame and identical handshake timing.
